// File: rtl/debounce_bank_pkg.sv
// Shared constants for the debouncer bank.
// Board tops use these defaults when sizing their debounce instances.
package debounce_bank_pkg;

    localparam int DEBOUNCE_NBITS_DEFAULT = 16;
    localparam int DEBOUNCE_NCH_DEFAULT   = 4;

endpackage

// File: rtl/debounce_bank_channel.sv
// One debounce channel: two-flop synchroniser, stability counter,
// debounced level and one-cycle rise/fall pulses.
module debounce_channel #(
    parameter int NBITS      = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in_raw,
    output logic level,
    output logic rise_p,
    output logic fall_p,
    output logic toggle_d
);

    logic             sync0_q;
    logic             sync1_q;
    logic [NBITS-1:0] cnt_q;
    logic [NBITS-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             fall_q;
    logic             mismatch;

    // Any agreement between the synchronised pin and the level restarts the window,
    // whether or not tick is high.
    always_comb begin
        mismatch = (sync1_q != level_q);
        cnt_d    = cnt_q;
        level_d  = level_q;
        if (!mismatch) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                level_d = ~level_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync0_q <= in_raw ^ ACTIVE_LOW;
            sync1_q <= sync0_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level    = level_q;
    assign rise_p   = rise_q;
    assign fall_p   = fall_q;
    assign toggle_d = level_d ^ level_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: NCH independent channels plus a registered
// "changed" flag that lines up with the rise/fall pulses.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int NCH        = DEBOUNCE_NCH_DEFAULT,
    parameter int NBITS      = DEBOUNCE_NBITS_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic [NCH-1:0] in_state,
    output logic [NCH-1:0] out_state,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           changed
);

    logic [NCH-1:0] toggle_next;
    logic           changed_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        debounce_channel #(
            .NBITS      (NBITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .in_raw   (in_state[i]),
            .level    (out_state[i]),
            .rise_p   (rise[i]),
            .fall_p   (fall[i]),
            .toggle_d (toggle_next[i])
        );
    end

    // Registered from the channels' next-state toggles so it rises with rise/fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |toggle_next;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with NCH=4, NBITS=4, ACTIVE_LOW=1.
// Inputs change and outputs are sampled 2 ns after each rising edge.
module tb_debounce_bank;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] in_state;
    logic [3:0] out_state;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int vectors;
    int miscompares;

    debounce_bank #(
        .NCH        (4),
        .NBITS      (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .in_state  (in_state),
        .out_state (out_state),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expOut, input logic [3:0] expRise,
                            input logic [3:0] expFall, input logic expChanged);
        checkOutput({tag, " out_state"}, out_state, expOut);
        checkOutput({tag, " rise"}, rise, expRise);
        checkOutput({tag, " fall"}, fall, expFall);
        checkOutput({tag, " changed"}, {3'b000, changed}, {3'b000, expChanged});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        tick        = 1'b1;
        in_state    = 4'hF;

        // All pins idle (high) through reset: nothing may move.
        repeat (3) applyStimulus();
        checkAll("in_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            applyStimulus();
            checkAll($sformatf("idle e%0d", e), 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        // Press on channel 0: accepted on edge 18, one-cycle rise and changed.
        in_state = 4'b1110;
        for (int e = 1; e <= 20; e++) begin
            applyStimulus();
            checkAll($sformatf("press0 e%0d", e),
                     (e >= 18) ? 4'b0001 : 4'b0000,
                     (e == 18) ? 4'b0001 : 4'b0000,
                     4'b0000, e == 18);
        end

        // Channel 3 bounces low for 10 cycles, high for 10, five times.
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 20; k++) begin
                in_state[3] = (k < 10) ? 1'b0 : 1'b1;
                applyStimulus();
                checkAll($sformatf("glitch3 r%0d k%0d", r, k), 4'b0001, 4'b0000, 4'b0000, 1'b0);
            end
        end

        // Tick high only before every 4th edge: 16 qualified edges end at edge 64.
        in_state[1] = 1'b0;
        for (int e = 1; e <= 70; e++) begin
            tick = ((e % 4) == 0);
            applyStimulus();
            checkAll($sformatf("gated1 e%0d", e),
                     (e >= 64) ? 4'b0011 : 4'b0001,
                     (e == 64) ? 4'b0010 : 4'b0000,
                     4'b0000, e == 64);
        end
        tick = 1'b1;

        // Channel 1 released and channel 2 pressed on the same cycle.
        in_state = 4'b1010;
        for (int e = 1; e <= 20; e++) begin
            applyStimulus();
            checkAll($sformatf("simul e%0d", e),
                     (e >= 18) ? 4'b0101 : 4'b0011,
                     (e == 18) ? 4'b0100 : 4'b0000,
                     (e == 18) ? 4'b0010 : 4'b0000, e == 18);
        end

        // Channel 3 pressed, reset pulsed mid-cycle at count 10.
        in_state = 4'b0010;
        for (int e = 1; e <= 12; e++) begin
            applyStimulus();
            checkAll($sformatf("pre_rst e%0d", e), 4'b0101, 4'b0000, 4'b0000, 1'b0);
        end
        #1 rst = 1'b1;
        #1 checkAll("async_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        #1 rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            applyStimulus();
            checkAll($sformatf("post_rst e%0d", e),
                     (e >= 18) ? 4'b1101 : 4'b0000,
                     (e == 18) ? 4'b1101 : 4'b0000,
                     4'b0000, e == 18);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
